morse_decoder: RTL
==================

MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter DASH_TH, default 2: mark length in units at or above which an element is a dash.
REQ-002 Parameter GAP_TH, default 3: space length in units that ends a letter.
REQ-003 Parameter CNT_W, default 4: width of the unit counter.
REQ-004 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port tick  input  1  one-cycle unit-time strobe; all sampling and timing are qualified by it.
REQ-007 Port morse_in  input  1  asynchronous keyed line; 1 = mark (key down), 0 = space.
REQ-008 Port letter_code  output  4  element bits, dot = 0, dash = 1, first element in bit 0.
REQ-009 Port letter_len  output  3  number of elements in the letter, 1..4.
REQ-010 Port letter_valid  output  1  one-cycle pulse; letter_code and letter_len are valid with it.
REQ-011 Port letter_err  output  1  set with letter_valid when the letter had more than 4 elements.

Function
REQ-012 morse_in shall pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-013 The FSM shall have states IDLE, MARK and SPACE, with transitions evaluated only in cycles where tick = 1.
REQ-014 IDLE: line = 1 -> MARK with cnt = 1, element count = 0, code = 0, err = 0; line = 0 -> stay in IDLE.
REQ-015 MARK: line = 1 -> cnt increments and saturates at 2^CNT_W-1; line = 0 -> classify the element (cnt >= DASH_TH is a dash, else a dot), store it, set cnt = 1, and go to SPACE.
REQ-016 Storing element number n (0-based): n <= 3 -> code[n] = bit and count = n+1; n >= 4 -> err = 1 and code/count are unchanged.
REQ-017 SPACE: line = 1 -> MARK with cnt = 1; line = 0 -> cnt increments; when the incremented value equals GAP_TH, pulse letter_valid and go to IDLE.
REQ-018 letter_valid shall assert the clock cycle after the tick that completes the gap and last exactly one cycle.
REQ-019 letter_code, letter_len and letter_err shall update with letter_valid and hold until the next letter_valid.
REQ-020 A mark shorter than one tick period that is never sampled high on a tick shall be ignored.
REQ-021 A mark in progress shall never emit a letter; a letter is emitted only after a space of GAP_TH units.
REQ-022 tick = 0 cycles shall leave all state unchanged except the synchronizer and the letter_valid deassertion.

Reset
REQ-023 On reset = 0, the block shall immediately enter IDLE, clear cnt, code, count and err, and drive letter_code = 0, letter_len = 0, letter_valid = 0 and letter_err = 0.
REQ-024 Reset mid-letter shall discard the partial letter with no letter_valid.
REQ-025 On reset release, the first element shall be recognized no earlier than 2 clk cycles later (synchronizer fill).

Structure
REQ-026 The FSM state encoding and the default DASH_TH/GAP_TH values shall live in shared package morse_pkg, which is also used by the transmitter.
REQ-027 The unit counter shall be sub-module morse_unit_counter (load-to-1, increment with saturation, tick enable).

Verification
REQ-028 Key ".-" (mark 1, space 1, mark 3, space 3 units) -> one letter_valid, code = 4'b0010, len = 2, err = 0.
REQ-029 Key "-.-" (K) -> code = 4'b0101, len = 3; a following "..." (S) after a 3-unit gap -> code = 4'b0000, len = 3.
REQ-030 Five dots then a 3-unit gap -> letter_valid with err = 1, len = 4, code = 4'b0000; the next letter "." -> err = 0, len = 1.
REQ-031 Reset asserted during the second element of "--" -> no letter_valid and outputs 0; after release, "." -> code = 0, len = 1.
REQ-032 Mark of exactly DASH_TH-1 units -> dot and exactly DASH_TH units -> dash; space of GAP_TH-1 units -> no letter end.
REQ-033 Mark of 20 units (counter saturation) -> dash, with no counter wrap.

Source files
------------

// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse keyer path (decoder and transmitter):
//   - morse_state_t : FSM state encoding (IDLE, MARK, SPACE)
//   - DASH_TH_DEF   : default mark length (units) at or above which an element
//                     is a dash
//   - GAP_TH_DEF    : default space length (units) that closes a letter
//   - MAX_ELEMS     : number of elements a letter can hold in letter_code
// -----------------------------------------------------------------------------
package morse_pkg;

  localparam int DASH_TH_DEF = 2;
  localparam int GAP_TH_DEF  = 3;
  localparam int MAX_ELEMS   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } morse_state_t;

endpackage

// File: rtl/morse_unit_counter.sv
// -----------------------------------------------------------------------------
// morse_unit_counter
// Counts unit-time ticks spent in the current mark or space.
// Ports:
//   clk   in  clock
//   reset in  asynchronous active-low reset (clears the count)
//   en    in  tick enable; the count only moves when en = 1
//   load  in  restart the count at 1 (first unit of a new mark/space)
//   inc   in  add one unit, holding at the all-ones value
//   cnt   out current unit count
// -----------------------------------------------------------------------------
module morse_unit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en) begin
      if (load) begin
        cnt <= CNT_ONE;
      end else if (inc && (cnt != CNT_MAX)) begin
        // Saturate so a very long mark still reads as a dash, never wraps.
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// -----------------------------------------------------------------------------
// morse_decoder
// Decodes a keyed Morse line into letters of up to four elements.
// Ports:
//   clk          in  clock; all state changes on the rising edge
//   reset        in  asynchronous active-low reset
//   tick         in  one-cycle unit-time strobe qualifying all sampling
//   morse_in     in  asynchronous key line, 1 = mark, 0 = space
//   letter_code  out element bits (dot 0, dash 1), first element in bit 0
//   letter_len   out number of stored elements, 1..4
//   letter_valid out one-cycle pulse marking a completed letter
//   letter_err   out letter had more than four elements
// -----------------------------------------------------------------------------
module morse_decoder
  import morse_pkg::*;
#(
  parameter int DASH_TH = DASH_TH_DEF,
  parameter int GAP_TH  = GAP_TH_DEF,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       morse_in,
  output logic [3:0] letter_code,
  output logic [2:0] letter_len,
  output logic       letter_valid,
  output logic       letter_err
);

  localparam logic [CNT_W-1:0] DASH_V = CNT_W'(DASH_TH);
  localparam logic [CNT_W-1:0] GAP_V  = CNT_W'(GAP_TH);
  localparam logic [2:0]       ELEM_MAX = 3'(MAX_ELEMS);

  // Two-flop synchronizer; only sync_q[1] is used by the decoder.
  logic [1:0] sync_q;
  logic       line;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], morse_in};
    end
  end

  assign line = sync_q[1];

  morse_state_t     state;
  logic [2:0]       elem_cnt;
  logic [3:0]       code;
  logic             err;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_load;
  logic             cnt_inc;
  logic             is_dash;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      IDLE:  cnt_load = line;
      MARK: begin
        cnt_inc  = line;
        cnt_load = !line;
      end
      SPACE: begin
        cnt_inc  = !line;
        cnt_load = line;
      end
      default: ;
    endcase
  end

  morse_unit_counter #(
    .CNT_W (CNT_W)
  ) u_unit_counter (
    .clk   (clk),
    .reset (reset),
    .en    (tick),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );

  // At the classifying tick, cnt holds the full mark length in units.
  assign is_dash  = (cnt >= DASH_V);
  // Gap detection looks at the value the counter is about to take.
  assign cnt_next = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      elem_cnt     <= '0;
      code         <= '0;
      err          <= 1'b0;
      letter_code  <= '0;
      letter_len   <= '0;
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
    end else begin
      letter_valid <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (line) begin
              state    <= MARK;
              elem_cnt <= '0;
              code     <= '0;
              err      <= 1'b0;
            end
          end
          MARK: begin
            if (!line) begin
              if (elem_cnt < ELEM_MAX) begin
                code[elem_cnt[1:0]] <= is_dash;
                elem_cnt            <= elem_cnt + 3'd1;
              end else begin
                // Fifth and later elements only flag the letter as bad.
                err <= 1'b1;
              end
              state <= SPACE;
            end
          end
          SPACE: begin
            if (line) begin
              state <= MARK;
            end else if (cnt_next == GAP_V) begin
              letter_valid <= 1'b1;
              letter_code  <= code;
              letter_len   <= elem_cnt;
              letter_err   <= err;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
